// File: rtl/pll_sup_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_sup_pkg : shared types and constants for the PLL lock supervisor       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package pll_sup_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } pll_state_e;

   localparam int RETRY_W = 4;
   localparam int LOSS_W  = 8;

   // Width able to hold (largest cycle count - 1); never narrower than 1 bit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_supervisor_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_2ff : single-bit two-flop synchroniser, synchronous reset to 0        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_lock_supervisor : drives PLL reset, qualifies lock, releases sys_rst   |
// | Optional macro PLL_LOSS_COUNT_EN adds the lock_loss_cnt output.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [2:0]         state_dbg
`ifdef PLL_LOSS_COUNT_EN
   ,
   output logic [LOSS_W-1:0]  lock_loss_cnt
`endif
);

   localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   pll_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               pll_rst_q, pll_rst_d;
   logic               sys_rst_q, sys_rst_d;
   logic               ready_q, ready_d;
   logic               fault_q, fault_d;
   logic               locked_s;
   logic               retries_done;

   sync_2ff u_lock_sync (
      .clk_i (refclk),
      .rst_i (rst),
      .d_i   (pll_locked),
      .q_o   (locked_s)
   );

   // A retry limit of zero never exhausts; a limit above 15 is never reached.
   assign retries_done = (MAX_RETRIES != 0) && (int'(retry_q) == MAX_RETRIES);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      case (state_q)
         RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TMO_LAST) begin
               cnt_d = '0;
               if (retries_done) begin
                  state_d = FAULT;
               end else begin
                  state_d = RESET_PLL;
                  if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STB_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
               retry_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_d = RESET_PLL;
               cnt_d   = '0;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = RESET_PLL;
            cnt_d   = '0;
         end
      endcase

      // Outputs decoded from the next state so they move with the state register.
      pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
      sys_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
      fault_d   = (state_d == FAULT);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= RESET_PLL;
         cnt_q     <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         fault_q   <= fault_d;
      end
   end

`ifdef PLL_LOSS_COUNT_EN
   logic [LOSS_W-1:0] loss_q;

   always_ff @(posedge refclk) begin
      if (rst) begin
         loss_q <= '0;
      end else if ((state_q == RUN) && (state_d == RESET_PLL) && (loss_q != '1)) begin
         loss_q <= loss_q + LOSS_W'(1);
      end
   end

   assign lock_loss_cnt = loss_q;
`endif

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pll_lock_supervisor : scoreboard bench, edge-tagged expected outputs    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pll_lock_supervisor;
   import pll_sup_pkg::*;

   typedef struct {
      int         tag;
      string      name;
      logic       pr;
      logic       sr;
      logic       rdy;
      logic       flt;
      logic [3:0] rc;
      logic [2:0] st;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic [3:0] retry_cnt;
   logic [2:0] state_dbg;
`ifdef PLL_LOSS_COUNT_EN
   logic [7:0] lock_loss_cnt;
`endif

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   pll_lock_supervisor #(
      .RST_PULSE_CYCLES    (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32),
      .MAX_RETRIES         (2)
   ) dut (
      .refclk     (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
      .state_dbg  (state_dbg)
`ifdef PLL_LOSS_COUNT_EN
      ,
      .lock_loss_cnt (lock_loss_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected output levels for each state, straight from the state descriptions.
   task automatic push(input int tag, input string name, input logic [2:0] st, input logic [3:0] rc);
      exp_t e;
      e.tag = tag; e.name = name; e.st = st; e.rc = rc;
      e.pr = 1'b0; e.sr = 1'b1; e.rdy = 1'b0; e.flt = 1'b0;
      case (st)
         RESET_PLL: e.pr = 1'b1;
         RUN:       begin e.sr = 1'b0; e.rdy = 1'b1; end
         FAULT:     begin e.pr = 1'b1; e.flt = 1'b1; end
         default:   ;
      endcase
      sb.push_back(e);
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic begin_reset(output int r);
      r          = cyc + 1;
      rst        = 1'b1;
      pll_locked = 1'b0;
   endtask

   task automatic release_reset(input int r);
      wait_until(r);
      rst = 1'b0;
   endtask

   // Monitor: after every edge, compare all entries tagged for that edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.tag < cyc) begin
               $display("FAIL %s: expectation for edge %0d not checked (now edge %0d)", e.name, e.tag, cyc);
            end else if ({pll_rst, sys_rst, ready, fault, retry_cnt, state_dbg} !==
                         {e.pr, e.sr, e.rdy, e.flt, e.rc, e.st}) begin
               $display("FAIL %s @edge %0d: got pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d state=%0d, want pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d state=%0d",
                        e.name, cyc, pll_rst, sys_rst, ready, fault, retry_cnt, state_dbg,
                        e.pr, e.sr, e.rdy, e.flt, e.rc, e.st);
            end else begin
               n_pass++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      rst        = 1'b1;
      pll_locked = 1'b0;
      @(negedge clk);

      // Lock 5 cycles after pll_rst falls, then lose lock in RUN and relock.
      begin_reset(r);
      push(r,      "s1_reset",      RESET_PLL, 0);
      push(r + 3,  "s1_pulse_end",  RESET_PLL, 0);
      push(r + 4,  "s1_wait",       WAIT_LOCK, 0);
      push(r + 10, "s1_sync_delay", WAIT_LOCK, 0);
      push(r + 11, "s1_stable",     STABLE,    0);
      push(r + 18, "s1_pre_run",    STABLE,    0);
      push(r + 19, "s1_run",        RUN,       0);
      push(r + 26, "s4_run_hold",   RUN,       0);
      push(r + 27, "s4_loss",       RESET_PLL, 0);
      push(r + 30, "s4_pulse_end",  RESET_PLL, 0);
      push(r + 31, "s4_wait",       WAIT_LOCK, 0);
      push(r + 41, "s4_pre_run",    STABLE,    0);
      push(r + 42, "s4_relock_run", RUN,       0);
      release_reset(r);
      wait_until(r + 8);  pll_locked = 1'b1;
      wait_until(r + 24); pll_locked = 1'b0;
      wait_until(r + 31); pll_locked = 1'b1;
      wait_until(r + 44);

      // No lock at all: two retries then FAULT; rst clears it.
      begin_reset(r);
      push(r,       "s2_reset",     RESET_PLL, 0);
      push(r + 35,  "s2_timeout0",  WAIT_LOCK, 0);
      push(r + 36,  "s2_retry1",    RESET_PLL, 1);
      push(r + 39,  "s2_pulse2",    RESET_PLL, 1);
      push(r + 40,  "s2_wait2",     WAIT_LOCK, 1);
      push(r + 71,  "s2_timeout1",  WAIT_LOCK, 1);
      push(r + 72,  "s2_retry2",    RESET_PLL, 2);
      push(r + 76,  "s2_wait3",     WAIT_LOCK, 2);
      push(r + 107, "s2_last_wait", WAIT_LOCK, 2);
      push(r + 108, "s2_fault",     FAULT,     2);
      push(r + 130, "s2_fault_hold", FAULT,    2);
      push(r + 131, "s2_rst_clear", RESET_PLL, 0);
      release_reset(r);
      wait_until(r + 130); rst = 1'b1;
      wait_until(r + 131); rst = 1'b0;
      wait_until(r + 133);

      // One retry, then a 1-cycle lock glitch while the stable counter is at 5.
      begin_reset(r);
      push(r,      "s3_reset",     RESET_PLL, 0);
      push(r + 36, "s3_retry1",    RESET_PLL, 1);
      push(r + 40, "s3_wait",      WAIT_LOCK, 1);
      push(r + 48, "s3_stable_c5", STABLE,    1);
      push(r + 49, "s3_glitch",    WAIT_LOCK, 1);
      push(r + 50, "s3_restable",  STABLE,    1);
      push(r + 57, "s3_pre_run",   STABLE,    1);
      push(r + 58, "s3_run_clr",   RUN,       0);
      release_reset(r);
      wait_until(r + 40); pll_locked = 1'b1;
      wait_until(r + 46); pll_locked = 1'b0;
      wait_until(r + 47); pll_locked = 1'b1;
      wait_until(r + 60);

      // rst during WAIT_LOCK with one retry used.
      begin_reset(r);
      push(r,      "s5_reset",     RESET_PLL, 0);
      push(r + 36, "s5_retry1",    RESET_PLL, 1);
      push(r + 45, "s5_wait",      WAIT_LOCK, 1);
      push(r + 46, "s5_mid_rst",   RESET_PLL, 0);
      release_reset(r);
      wait_until(r + 45); rst = 1'b1;
      wait_until(r + 46); rst = 1'b0;
      wait_until(r + 48);

`ifdef PLL_LOSS_COUNT_EN
      begin_reset(r);
      release_reset(r);
      pll_locked = 1'b1;
      for (int i = 0; i < 260; i++) begin
         for (int k = 0; k < 200 && ready !== 1'b1; k++) @(negedge clk);
         pll_locked = 1'b0;
         for (int k = 0; k < 200 && ready !== 1'b0; k++) @(negedge clk);
         pll_locked = 1'b1;
      end
      wait_until(cyc + 4);
      n_checks++;
      if (lock_loss_cnt !== 8'd255)
         $display("FAIL s6_loss_sat: got lock_loss_cnt=%0d, want 255", lock_loss_cnt);
      else
         n_pass++;
`endif

      repeat (4) @(negedge clk);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_checks++;
         $display("FAIL %s: expectation for edge %0d never checked", e.name, e.tag);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
